// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: command FIFO, inhibit/start sequencing, per-phase timeout, ack check.
// Optional macro PS2_TX_RETRY_EN re-sends a failed byte up to MAX_RETRIES times before flagging ERROR.
module ps2_host_transmitter #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_RETRIES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CLK_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  input  logic       DATA_MOUSE_IN,
  output logic       DATA_MOUSE_OUT,
  output logic       DATA_MOUSE_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       READY,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic       ERROR,
  output logic [1:0] ERROR_CODE
);
  localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TMR_MAX     = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int TW          = $clog2(TMR_MAX + 1);
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CW          = $clog2(FIFO_DEPTH + 1);
`ifdef PS2_TX_RETRY_EN
  localparam int RETRY_ON    = 1;
`else
  localparam int RETRY_ON    = 0;
`endif
  localparam int RETRY_LIMIT = MAX_RETRIES * RETRY_ON;

  typedef enum logic [3:0] {
    IDLE, INHIBIT, START, WAIT_FIRST, DATA, PARITY, STOP, ACK_DATA, ACK_WAIT
  } state_t;

  state_t          state, state_n;
  logic            clk_s1, clk_s2, clk_d, dat_s1, dat_s2, fall;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_n;
  logic            full, push, pop, ovf;
  logic [7:0]      shreg, shreg_n;
  logic [2:0]      idx, idx_n;
  logic [TW-1:0]   tmr, tmr_n;
  logic [7:0]      retry_cnt, retry_n;
  logic            timed, fail, fsm_err, sent_n, den_n, dout_n;
  logic [1:0]      fail_code;

  // Sync flops idle high so reset release never looks like a clock fall.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      {clk_s1, clk_s2, clk_d, dat_s1, dat_s2} <= '1;
    end else begin
      clk_s1 <= CLK_MOUSE_IN;  clk_s2 <= clk_s1;  clk_d <= clk_s2;
      dat_s1 <= DATA_MOUSE_IN; dat_s2 <= dat_s1;
    end
  end
  assign fall = clk_d & ~clk_s2;

  assign full = (count == CW'(FIFO_DEPTH));
  assign push = SEND_BYTE & ~full;
  assign ovf  = SEND_BYTE & full;

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (!push && pop) count_n = count - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= BYTE_TO_SEND;
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    shreg_n   = shreg;
    tmr_n     = '0;
    retry_n   = retry_cnt;
    pop       = 1'b0;
    sent_n    = 1'b0;
    fail      = 1'b0;
    fsm_err   = 1'b0;
    fail_code = 2'b00;
    timed     = state inside {WAIT_FIRST, DATA, PARITY, STOP, ACK_DATA, ACK_WAIT};
    if (timed) tmr_n = fall ? '0 : tmr + 1'b1;
    case (state)
      IDLE:       if (count != '0) begin
                    pop = 1'b1; shreg_n = mem[rd_ptr]; retry_n = '0; state_n = INHIBIT;
                  end
      INHIBIT:    if (tmr == TW'(INHIBIT_CYC - 1)) state_n = START;
                  else tmr_n = tmr + 1'b1;
      START:      state_n = WAIT_FIRST;
      WAIT_FIRST: if (fall) begin state_n = DATA; idx_n = 3'd0; end
      DATA:       if (fall) begin
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) state_n = PARITY;
                  end
      PARITY:     if (fall) state_n = STOP;
      STOP:       if (fall) state_n = ACK_DATA;
      ACK_DATA:   if (fall) begin
                    if (dat_s2) begin fail = 1'b1; fail_code = 2'b10; end
                    else state_n = ACK_WAIT;
                  end
      ACK_WAIT:   if (clk_s2 && dat_s2) begin sent_n = 1'b1; state_n = IDLE; end
      default:    state_n = IDLE;
    endcase
    if (timed && !fall && !sent_n && tmr == TW'(TIMEOUT_CYC - 1)) begin
      fail = 1'b1; fail_code = 2'b01;
    end
    if (fail) begin
      tmr_n = '0;
      if (retry_cnt != 8'(RETRY_LIMIT)) begin
        retry_n = retry_cnt + 8'd1; state_n = INHIBIT;
      end else begin
        fsm_err = 1'b1; state_n = IDLE;
      end
    end
  end

  // Data pad follows the next state so a failure releases it at once;
  // the clock pad follows the current state, giving the two-edge start latency.
  always_comb begin
    den_n  = 1'b0;
    dout_n = 1'b0;
    case (state_n)
      START, WAIT_FIRST: den_n = 1'b1;
      DATA:              begin den_n = 1'b1; dout_n = shreg_n[idx_n]; end
      PARITY:            begin den_n = 1'b1; dout_n = ~^shreg_n; end
      STOP:              begin den_n = 1'b1; dout_n = 1'b1; end
      default:           ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state             <= IDLE;
      idx               <= '0;
      shreg             <= '0;
      tmr               <= '0;
      retry_cnt         <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      CLK_MOUSE_OUT_EN  <= 1'b0;
      DATA_MOUSE_OUT    <= 1'b0;
      DATA_MOUSE_OUT_EN <= 1'b0;
      READY             <= 1'b1;
      BUSY              <= 1'b0;
      BYTE_SENT         <= 1'b0;
      ERROR             <= 1'b0;
      ERROR_CODE        <= 2'b00;
    end else begin
      state             <= state_n;
      idx               <= idx_n;
      shreg             <= shreg_n;
      tmr               <= tmr_n;
      retry_cnt         <= retry_n;
      count             <= count_n;
      if (push) wr_ptr  <= wr_ptr + 1'b1;
      if (pop)  rd_ptr  <= rd_ptr + 1'b1;
      CLK_MOUSE_OUT_EN  <= (state == INHIBIT);
      DATA_MOUSE_OUT    <= dout_n;
      DATA_MOUSE_OUT_EN <= den_n;
      READY             <= (count_n != CW'(FIFO_DEPTH));
      BUSY              <= (state_n != IDLE) || (count_n != '0);
      BYTE_SENT         <= sent_n;
      ERROR             <= fsm_err | ovf;
      if (fsm_err)  ERROR_CODE <= fail_code;
      else if (ovf) ERROR_CODE <= 2'b11;
    end
  end
endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Self-checking bench: behavioural PS/2 device on the open-drain pads, randomized bytes, scoreboard queue.
module tb_ps2_host_transmitter;
  localparam int INH = 100;
  localparam int TO  = 2000;
  localparam int H   = 20;
  localparam int BUDGET = 8000;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       CLK = 0, RESET_N = 1, SEND_BYTE = 0;
  logic [7:0] BYTE_TO_SEND = 0;
  logic       dev_clk = 1, dev_data = 1;
  logic       CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN;
  logic       READY, BUSY, BYTE_SENT, ERROR;
  logic [1:0] ERROR_CODE;
  logic       clk_pad, data_pad;
  int         checks = 0, errors = 0, sent_cnt = 0, err_cnt = 0;

  assign clk_pad  = dev_clk & ~CLK_MOUSE_OUT_EN;
  assign data_pad = dev_data & (DATA_MOUSE_OUT_EN ? DATA_MOUSE_OUT : 1'b1);

  ps2_host_transmitter #(
    .CLK_FREQ_HZ(1_000_000), .INHIBIT_US(INH), .TIMEOUT_US(TO), .FIFO_DEPTH(4), .MAX_RETRIES(2)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CLK_MOUSE_IN(clk_pad), .CLK_MOUSE_OUT_EN(CLK_MOUSE_OUT_EN),
    .DATA_MOUSE_IN(data_pad), .DATA_MOUSE_OUT(DATA_MOUSE_OUT), .DATA_MOUSE_OUT_EN(DATA_MOUSE_OUT_EN),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
    .READY(READY), .BUSY(BUSY), .BYTE_SENT(BYTE_SENT), .ERROR(ERROR), .ERROR_CODE(ERROR_CODE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (BYTE_SENT) sent_cnt++;
    if (ERROR)     err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic push(input logic [7:0] b);
    @(negedge CLK);
    SEND_BYTE = 1; BYTE_TO_SEND = b;
    @(negedge CLK);
    SEND_BYTE = 0;
  endtask

  // Device side of one frame: waits out the inhibit, clocks 12 pulses, samples on
  // rising edges, optionally acks. stop_after>0 abandons the frame after that many pulses.
  task automatic dev_frame(input bit ack, input int stop_after, output logic [7:0] b,
                           output logic par, output logic stp, output int inh);
    int n;
    b = '0; par = 0; stp = 0; inh = 0; n = 0;
    do begin @(negedge CLK); n++; end while (!CLK_MOUSE_OUT_EN && n < BUDGET);
    if (!CLK_MOUSE_OUT_EN) begin chk("inhibit_seen", 0, 1); return; end
    while (CLK_MOUSE_OUT_EN && inh < BUDGET) begin inh++; @(negedge CLK); end
    chk("start_bit", {DATA_MOUSE_OUT_EN, DATA_MOUSE_OUT}, 2'b10);
    repeat (5) @(negedge CLK);
    for (int k = 1; k <= 12; k++) begin
      if (stop_after > 0 && k > stop_after) return;
      dev_clk = 0;
      repeat (H) @(negedge CLK);
      if (k <= 8)       b[k-1] = data_pad;
      else if (k == 9)  par = data_pad;
      else if (k == 10) stp = data_pad;
      dev_clk = 1;
      repeat (H/2) @(negedge CLK);
      if (k == 11 && ack) dev_data = 0;
      repeat (H - H/2) @(negedge CLK);
    end
    dev_data = 1;
  endtask

  task automatic send_one(input logic [7:0] val, input bit lat);
    logic [7:0] rb; logic p, s; int inh, s0, e0;
    s0 = sent_cnt; e0 = err_cnt;
    fork
      dev_frame(1'b1, 0, rb, p, s, inh);
      begin
        push(val);
        if (lat) begin
          @(negedge CLK); chk("latency_n1", CLK_MOUSE_OUT_EN, 0);
          @(negedge CLK); chk("latency_n2", CLK_MOUSE_OUT_EN, 1);
        end
      end
    join
    repeat (20) @(negedge CLK);
    chk("rx_byte", rb, val);
    chk("parity", p, odd_par(val));
    chk("stop", s, 1);
    chk("inhibit_len", inh, INH);
    chk("sent_pulse", sent_cnt - s0, 1);
    chk("no_error", err_cnt - e0, 0);
  endtask

  initial begin
    logic [7:0] rb, v; logic p, s; int inh, s0, e0, t, mcnt, lo, hi; bit stray;
    logic [7:0] expq[$], rxq[$];

    #3 RESET_N = 0;
    repeat (3) @(negedge CLK);
    chk("rst_enables", {CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN, DATA_MOUSE_OUT}, 0);
    chk("rst_ready", READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_pulses", {BYTE_SENT, ERROR, ERROR_CODE}, 0);
    RESET_N = 1;
    repeat (5) @(negedge CLK);

    send_one(8'hF4, 1'b1);
    for (int i = 0; i < 4; i++) send_one(8'($urandom), 1'b0);

    // Device never clocks: timeout in WAIT_FIRST.
    e0 = err_cnt;
    push(8'hFF);
    t = 0;
    while (!ERROR && t < BUDGET) begin @(negedge CLK); t++; end
    lo = ATTEMPTS * (INH + TO + 1) + 1 - 4;
    hi = lo + 8;
    chk("timeout_seen", ERROR, 1);
    chk("timeout_code", ERROR_CODE, 2'b01);
    chk("timeout_time_ok", (t >= lo && t <= hi), 1);
    chk("timeout_released", {CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN}, 0);
    repeat (5) @(negedge CLK);
    chk("timeout_err_once", err_cnt - e0, 1);
    chk("timeout_idle", BUSY, 0);

    // No acknowledge.
    e0 = err_cnt; s0 = sent_cnt;
    fork
      for (int i = 0; i < ATTEMPTS; i++) begin
        dev_frame(1'b0, 0, rb, p, s, inh);
        chk("nack_byte", rb, 8'hFF);
        chk("nack_parity", p, 1);
      end
      push(8'hFF);
    join
    t = 0;
    while (err_cnt == e0 && t < 200) begin @(negedge CLK); t++; end
    repeat (5) @(negedge CLK);
    chk("nack_err_once", err_cnt - e0, 1);
    chk("nack_code", ERROR_CODE, 2'b10);
    chk("nack_no_sent", sent_cnt - s0, 0);

    // FIFO fill and overflow while the first frame is in its inhibit.
    e0 = err_cnt; s0 = sent_cnt; mcnt = 0;
    expq.delete(); rxq.delete();
    fork
      for (int i = 0; i < 5; i++) begin
        dev_frame(1'b1, 0, rb, p, s, inh);
        rxq.push_back(rb);
      end
      begin
        v = 8'($urandom);
        expq.push_back(v);
        push(v);
        repeat (10) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
          chk("ready_before_push", READY, mcnt < 4);
          v = 8'($urandom);
          SEND_BYTE = 1; BYTE_TO_SEND = v;
          if (mcnt < 4) begin expq.push_back(v); mcnt++; end
          @(negedge CLK);
        end
        SEND_BYTE = 0;
        chk("ovf_ready", READY, 0);
        chk("ovf_error", ERROR, 1);
        chk("ovf_code", ERROR_CODE, 2'b11);
      end
    join
    repeat (20) @(negedge CLK);
    chk("fifo_count", rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) chk("fifo_order", rxq[i], expq[i]);
    chk("fifo_sent", sent_cnt - s0, 5);
    chk("fifo_err", err_cnt - e0, 1);
    chk("fifo_drained", BUSY, 0);

    // Reset in the middle of bit 3.
    v = 8'($urandom);
    fork
      dev_frame(1'b1, 4, rb, p, s, inh);
      push(v);
    join
    chk("pre_rst_den", DATA_MOUSE_OUT_EN, 1);
    chk("pre_rst_bit3", DATA_MOUSE_OUT, v[3]);
    #2 RESET_N = 0;
    #1;
    chk("rst_mid_enables", {CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN}, 0);
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_ready", READY, 1);
    @(negedge CLK);
    RESET_N = 1;
    s0 = sent_cnt; e0 = err_cnt; stray = 0;
    repeat (400) begin
      @(negedge CLK);
      if (CLK_MOUSE_OUT_EN || DATA_MOUSE_OUT_EN) stray = 1;
    end
    chk("no_stray_frame", stray, 0);
    chk("no_stray_pulses", (sent_cnt - s0) + (err_cnt - e0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
